// File: rtl/theta_acc_if.sv
// theta_acc_if: request/result bus between the motion/control units and theta_acc_scheduler.
//   req        - per-channel update request (level, held until ack)
//   delta_flat - per-channel signed delta, channel i at [i*DW +: DW]
//   ack        - one-hot completion pulse for the served channel
//   theta_flat - current theta per channel, channel i at [i*TW +: TW]
//   theta_out  - normalized result of the last completed update
//   chan_out   - channel index of the last completed update
//   soma/normaliza/busy/done - datapath phase and status flags
interface theta_acc_if #(
    parameter int N_REQ = 4,
    parameter int TW    = 9,
    parameter int DW    = 9
);
    localparam int CW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] delta_flat;
    logic [N_REQ-1:0]    ack;
    logic [N_REQ*TW-1:0] theta_flat;
    logic [TW-1:0]       theta_out;
    logic [CW-1:0]       chan_out;
    logic                soma;
    logic                normaliza;
    logic                busy;
    logic                done;
    modport master (
        output req, delta_flat,
        input  ack, theta_flat, theta_out, chan_out, soma, normaliza, busy, done
    );
    modport slave (
        input  req, delta_flat,
        output ack, theta_flat, theta_out, chan_out, soma, normaliza, busy, done
    );
endinterface

// File: rtl/theta_acc_scheduler.sv
// theta_acc_scheduler: round-robin arbiter sharing one add/normalize datapath across N_REQ heading registers.
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - theta_acc_if slave: req/delta_flat in; ack, theta_flat, theta_out, chan_out,
//           soma, normaliza, busy, done out (all outputs registered)
module theta_acc_scheduler #(
    parameter int N_REQ = 4,
    parameter int TW    = 9,
    parameter int DW    = 9
) (
    input logic       clk,
    input logic       reset,
    theta_acc_if.slave bus
);
    localparam int CW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW = TW + 2;

    typedef enum logic [1:0] {IDLE, SOMA, NORMALIZA, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       chan_q, chan_d, ptr_q, ptr_d, chan_out_q, chan_out_d, win;
    logic [DW-1:0]       delta_q, delta_d;
    logic signed [SW-1:0] sum_q, sum_d;
    logic [N_REQ*TW-1:0] theta_q, theta_d;
    logic [TW-1:0]       theta_out_q, theta_out_d, theta_cur, result;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                soma_q, soma_d, norm_q, norm_d, busy_q, busy_d, done_q, done_d;

    // Winner: first requesting channel at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        win   = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx -= N_REQ;
            if (!found && bus.req[idx]) begin
                win   = CW'(idx);
                found = 1'b1;
            end
        end
    end

    assign theta_cur = theta_q[chan_q*TW +: TW];
    // A single +/-360 correction covers the whole -256..614 sum range.
    assign result = sum_q[SW-1] ? TW'(sum_q + SW'(360)) :
                    (sum_q >= SW'(360)) ? TW'(sum_q - SW'(360)) : TW'(sum_q);

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        delta_d     = delta_q;
        sum_d       = sum_q;
        theta_d     = theta_q;
        theta_out_d = theta_out_q;
        chan_out_d  = chan_out_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: if (|bus.req) begin
                state_d = SOMA;
                chan_d  = win;
                delta_d = bus.delta_flat[win*DW +: DW];
            end
            SOMA: begin
                sum_d   = $signed({2'b00, theta_cur}) + $signed({{(SW-DW){delta_q[DW-1]}}, delta_q});
                state_d = NORMALIZA;
            end
            NORMALIZA: begin
                theta_d[chan_q*TW +: TW] = result;
                theta_out_d = result;
                chan_out_d  = chan_q;
                ptr_d       = (chan_q == CW'(N_REQ-1)) ? '0 : chan_q + 1'b1;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
        // Status flags are registered copies of the next state, so they line up with the state itself.
        soma_d = state_d == SOMA;
        norm_d = state_d == NORMALIZA;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        ack_d  = done_d ? N_REQ'(1) << chan_q : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            ptr_q       <= '0;
            delta_q     <= '0;
            sum_q       <= '0;
            theta_q     <= '0;
            theta_out_q <= '0;
            chan_out_q  <= '0;
            ack_q       <= '0;
            soma_q      <= 1'b0;
            norm_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            ptr_q       <= ptr_d;
            delta_q     <= delta_d;
            sum_q       <= sum_d;
            theta_q     <= theta_d;
            theta_out_q <= theta_out_d;
            chan_out_q  <= chan_out_d;
            ack_q       <= ack_d;
            soma_q      <= soma_d;
            norm_q      <= norm_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.theta_flat = theta_q;
    assign bus.theta_out  = theta_out_q;
    assign bus.chan_out   = chan_out_q;
    assign bus.soma       = soma_q;
    assign bus.normaliza  = norm_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_theta_acc_scheduler.sv
// tb_theta_acc_scheduler: directed self-checking bench for theta_acc_scheduler.
module tb_theta_acc_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   c;

    theta_acc_if #(.N_REQ(4), .TW(9), .DW(9)) bus ();
    theta_acc_scheduler #(.N_REQ(4), .TW(9), .DW(9)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_delta(input int ch, input int d);
        bus.delta_flat[ch*9 +: 9] = 9'(d);
    endtask

    function automatic logic [8:0] th(input int ch);
        return bus.theta_flat[ch*9 +: 9];
    endfunction

    // Counts negedges until an ack shows up, bounded so a dead DUT still ends the run.
    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.ack == '0 && cyc < 12);
    endtask

    task automatic serve(input string tag, input int ch, input int d, input int exp_theta);
        set_delta(ch, d);
        bus.req[ch] = 1'b1;
        wait_ack(c);
        chk({tag, "_ack"}, bus.ack, 32'(1) << ch);
        chk({tag, "_theta"}, th(ch), exp_theta);
        chk({tag, "_theta_out"}, bus.theta_out, exp_theta);
        chk({tag, "_chan_out"}, bus.chan_out, ch);
        bus.req[ch] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = '0;
        bus.delta_flat = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_theta_flat", bus.theta_flat, 0);
        chk("rst_theta_out", bus.theta_out, 0);
        chk("rst_chan_out", bus.chan_out, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_flags", {bus.done, bus.soma, bus.normaliza, bus.busy}, 0);

        // Basic update with cycle-exact phase checks.
        set_delta(0, 10);
        bus.req[0] = 1'b1;
        @(negedge clk);
        chk("t1_soma", {bus.soma, bus.normaliza, bus.busy, bus.done}, 4'b1010);
        @(negedge clk);
        chk("t1_norm", {bus.soma, bus.normaliza, bus.busy, bus.done}, 4'b0110);
        chk("t1_no_ack_yet", bus.ack, 0);
        @(negedge clk);
        chk("t1_ack", bus.ack, 4'b0001);
        chk("t1_done", {bus.soma, bus.normaliza, bus.busy, bus.done}, 4'b0011);
        chk("t1_theta0", th(0), 10);
        chk("t1_theta_out", bus.theta_out, 10);
        chk("t1_chan_out", bus.chan_out, 0);
        bus.req[0] = 1'b0;
        @(negedge clk);
        chk("t1_ack_drop", {bus.ack, bus.done, bus.busy}, 0);

        // Positive wrap.
        serve("p1", 1, 255, 255);
        serve("p2", 1, 95, 350);
        serve("p3", 1, 20, 10);
        serve("p4", 1, 255, 265);
        serve("p5", 1, 94, 359);
        serve("p6", 1, 255, 254);

        // Negative wrap.
        serve("n1", 2, 5, 5);
        serve("n2", 2, -10, 355);
        serve("n3", 3, -256, 104);
        chk("n_theta0_kept", th(0), 10);

        // Contention: all held, order 0,1,2,3 with acks 4 cycles apart.
        for (int i = 0; i < 4; i++) set_delta(i, 1);
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(c);
            chk("rr_ack", bus.ack, 32'(1) << i);
            chk("rr_gap", c, (i == 0) ? 3 : 4);
            bus.req[i] = 1'b0;
        end
        chk("rr_theta_flat", bus.theta_flat, {9'd105, 9'd356, 9'd255, 9'd11});
        set_delta(2, 2);
        bus.req = 4'b0101;
        wait_ack(c);
        chk("rr2_first", bus.ack, 4'b0001);
        wait_ack(c);
        chk("rr2_second", bus.ack, 4'b0100);
        chk("rr2_gap", c, 4);
        wait_ack(c);
        chk("rr2_third", bus.ack, 4'b0001);
        bus.req = '0;
        @(negedge clk);
        chk("rr2_theta0", th(0), 13);
        chk("rr2_theta2", th(2), 358);

        // Reset during NORMALIZA aborts the update.
        set_delta(1, 30);
        bus.req[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ra_norm", bus.normaliza, 1);
        reset = 1'b1;
        #1;
        chk("ra_theta_flat", bus.theta_flat, 0);
        @(negedge clk);
        chk("ra_no_ack", {bus.ack, bus.done}, 0);
        chk("ra_busy", bus.busy, 0);
        reset = 1'b0;
        wait_ack(c);
        chk("ra_ack", bus.ack, 4'b0010);
        chk("ra_latency", c, 3);
        chk("ra_theta1", th(1), 30);
        chk("ra_others", {th(3), th(2), th(0)}, 0);
        bus.req[1] = 1'b0;
        @(negedge clk);

        // Glitch request while busy is never served.
        set_delta(0, 5);
        set_delta(3, 7);
        bus.req[0] = 1'b1;
        @(negedge clk);
        bus.req[3] = 1'b1;
        @(negedge clk);
        bus.req[3] = 1'b0;
        wait_ack(c);
        chk("gl_ack0", bus.ack, 4'b0001);
        chk("gl_theta0", th(0), 5);
        bus.req[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("gl_no_ack", {bus.ack, bus.busy}, 0);
        end
        chk("gl_theta3", th(3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
